mgmt_arb: RTL and testbench

Two-master arbiter for the single-slave management bus that reaches the control/status register map (vector, EPC, status, mask, MC PHY and perf-counter registers). It grants the core (m0) and debug/host port (m1) round-robin, forwards one transaction at a time, and returns the slave's completion to the granted master. A timeout can retire transactions that no slave acknowledges.

---
 rtl/mgmt_arb.sv | 141 ++++++++++++++
 tb/tb_mgmt_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_arb.sv
// mgmt_arb: round-robin arbiter of two masters onto the single-slave management bus; 4 cycles request-to-ack, one transaction per 5 cycles.
// Define MGMT_ARB_TIMEOUT_EN to retire transactions with no mgmt_ack after TIMEOUT busy cycles (mX_err = 1).
module mgmt_arb
`ifdef MGMT_ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 15
)
`endif
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic [31:0] m0_adr,
  input  logic        m0_rwn,
  input  logic [1:0]  m0_wen,
  input  logic [31:0] m0_txd,
  output logic        m0_ack,
  output logic        m0_rxe,
  output logic [31:0] m0_rxd,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_adr,
  input  logic        m1_rwn,
  input  logic [1:0]  m1_wen,
  input  logic [31:0] m1_txd,
  output logic        m1_ack,
  output logic        m1_rxe,
  output logic [31:0] m1_rxd,
  output logic        m1_err,
  output logic        mgmt_req,
  output logic [31:0] mgmt_adr,
  output logic        mgmt_rwn,
  output logic [1:0]  mgmt_wen,
  output logic [31:0] mgmt_txd,
  input  logic        mgmt_ack,
  input  logic        mgmt_rxe,
  input  logic [31:0] mgmt_rxd
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state;
  logic   last;  // master granted most recently; resets to m1 so m0 wins the first tie
  logic   gnt;
  logic   pick;

`ifdef MGMT_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  logic [7:0] cnt;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  assign pick = m1_req & (~m0_req | ~last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      mgmt_req <= 1'b0;
      mgmt_adr <= '0;
      mgmt_rwn <= 1'b0;
      mgmt_wen <= '0;
      mgmt_txd <= '0;
      m0_ack   <= 1'b0;
      m0_rxe   <= 1'b0;
      m0_rxd   <= '0;
      m1_ack   <= 1'b0;
      m1_rxe   <= 1'b0;
      m1_rxd   <= '0;
`ifdef MGMT_ARB_TIMEOUT_EN
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      // Completion outputs are single-cycle pulses, zero unless set below.
      m0_ack <= 1'b0;
      m0_rxe <= 1'b0;
      m0_rxd <= '0;
      m1_ack <= 1'b0;
      m1_rxe <= 1'b0;
      m1_rxd <= '0;
`ifdef MGMT_ARB_TIMEOUT_EN
      m0_err <= 1'b0;
      m1_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            gnt      <= pick;
            mgmt_req <= 1'b1;
            mgmt_adr <= pick ? m1_adr : m0_adr;
            mgmt_rwn <= pick ? m1_rwn : m0_rwn;
            mgmt_wen <= pick ? m1_wen : m0_wen;
            mgmt_txd <= pick ? m1_txd : m0_txd;
`ifdef MGMT_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mgmt_ack) begin
            mgmt_req <= 1'b0;
            state    <= RESP;
            if (gnt) begin
              m1_ack <= 1'b1;
              m1_rxe <= mgmt_rxe;
              m1_rxd <= mgmt_rxd;
            end else begin
              m0_ack <= 1'b1;
              m0_rxe <= mgmt_rxe;
              m0_rxd <= mgmt_rxd;
            end
          end
`ifdef MGMT_ARB_TIMEOUT_EN
          else if (cnt == TMO) begin
            mgmt_req <= 1'b0;
            state    <= RESP;
            m0_ack   <= ~gnt;
            m0_err   <= ~gnt;
            m1_ack   <= gnt;
            m1_err   <= gnt;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_arb.sv
// Bench for mgmt_arb: transaction-timeline model compared every cycle, plus literal checks of latency, ordering and reset.
module tb_mgmt_arb;

  typedef struct packed {
    logic [31:0] adr;
    logic        rwn;
    logic [1:0]  wen;
    logic [31:0] txd;
  } txn_t;

  localparam logic [31:0] ADR_MSTA = 32'h0000_0010;
`ifdef MGMT_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 15;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req [2];
  txn_t        fld [2];
  logic        m0_ack, m0_rxe, m0_err, m1_ack, m1_rxe, m1_err;
  logic [31:0] m0_rxd, m1_rxd;
  logic        mgmt_req, mgmt_rwn, mgmt_ack, mgmt_rxe;
  logic [31:0] mgmt_adr, mgmt_txd, mgmt_rxd;
  logic [1:0]  mgmt_wen;
  logic [1:0]  ackv;

  txn_t mq [2][$];
  int   idx [2];
  int   slat;
  int   stray_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state
  bit          busy;
  txn_t        exp_bus;
  int          gm, last_g, t_grant, free_at, cyc;
  logic        e_ack [2];
  logic        e_rxe [2];
  logic        e_err [2];
  logic [31:0] e_rxd [2];

  logic [63:0] glog [$];
  int          gap [$];

  assign ackv = {m1_ack, m0_ack};

  always #5 clk = ~clk;

  mgmt_arb dut (
    .clk(clk), .rstn(rstn),
    .m0_req(req[0]), .m0_adr(fld[0].adr), .m0_rwn(fld[0].rwn), .m0_wen(fld[0].wen), .m0_txd(fld[0].txd),
    .m0_ack(m0_ack), .m0_rxe(m0_rxe), .m0_rxd(m0_rxd), .m0_err(m0_err),
    .m1_req(req[1]), .m1_adr(fld[1].adr), .m1_rwn(fld[1].rwn), .m1_wen(fld[1].wen), .m1_txd(fld[1].txd),
    .m1_ack(m1_ack), .m1_rxe(m1_rxe), .m1_rxd(m1_rxd), .m1_err(m1_err),
    .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd),
    .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a == ADR_MSTA) ? 32'h0000_0003 : (a ^ 32'h5A5A_0000);
  endfunction

  // Masters: raise the next queued transaction, drop req on the edge after seeing ack.
  initial begin
    req[0] = 1'b0; req[1] = 1'b0; fld[0] = '0; fld[1] = '0; idx[0] = 0; idx[1] = 0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (req[g] && ackv[g]) begin
          req[g] = 1'b0;
          idx[g]++;
        end else if (!req[g] && idx[g] < mq[g].size()) begin
          fld[g] = mq[g][idx[g]];
          req[g] = 1'b1;
        end
      end
    end
  end

  // Slave: ack on the slat-th cycle of a request (0 = never); can also emit a stray ack while idle.
  initial begin
    int scnt, sdone;
    scnt = 0; sdone = 0;
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    forever begin
      @(negedge clk);
      if (mgmt_ack) begin
        mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
      end else if (stray_cnt != sdone && !mgmt_req) begin
        sdone++;
        mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'hFFFF_FFFF;
      end else if (!mgmt_req) begin
        scnt = 0;
      end else begin
        scnt++;
        if (slat != 0 && scnt == slat) begin
          mgmt_ack = 1'b1;
          mgmt_rxe = mgmt_rwn;
          mgmt_rxd = mgmt_rwn ? rdata(mgmt_adr) : 32'h0;
        end
      end
    end
  end

  // Model: one transaction at a time on a cycle timeline; next grant no earlier than two cycles after completion.
  task automatic mreset();
    busy = 1'b0; free_at = 0; last_g = 1; exp_bus = '0; gm = 0; t_grant = 0;
    for (int g = 0; g < 2; g++) begin
      e_ack[g] = 1'b0; e_rxe[g] = 1'b0; e_err[g] = 1'b0; e_rxd[g] = '0;
    end
  endtask

  task automatic finish_txn(input logic rxe, input logic [31:0] rxd, input logic err);
    e_ack[gm] = 1'b1; e_rxe[gm] = rxe; e_rxd[gm] = rxd; e_err[gm] = err;
    busy = 1'b0; free_at = cyc + 2; last_g = gm;
  endtask

  initial begin
    cyc = 0;
    mreset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) mreset();
      else begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
          e_ack[g] = 1'b0; e_rxe[g] = 1'b0; e_err[g] = 1'b0; e_rxd[g] = '0;
        end
        if (busy) begin
          if (mgmt_ack) finish_txn(mgmt_rxe, mgmt_rxd, 1'b0);
`ifdef MGMT_ARB_TIMEOUT_EN
          else if (cyc - t_grant > TIMEOUT) finish_txn(1'b0, 32'h0, 1'b1);
`endif
        end else if (cyc >= free_at && (req[0] || req[1])) begin
          gm = (req[0] && req[1]) ? 1 - last_g : (req[1] ? 1 : 0);
          exp_bus = fld[gm];
          t_grant = cyc;
          busy = 1'b1;
        end
      end
    end
  end

  // Compare every cycle away from the active edge.
  initial forever begin
    @(negedge clk);
    check("mgmt_bus", {mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd}, {busy, exp_bus});
    check("m0_rsp", {m0_ack, m0_rxe, m0_rxd, m0_err}, {e_ack[0], e_rxe[0], e_rxd[0], e_err[0]});
    check("m1_rsp", {m1_ack, m1_rxe, m1_rxd, m1_err}, {e_ack[1], e_rxe[1], e_rxd[1], e_err[1]});
  end

  // Grant log: {adr, txd} at each mgmt_req rise, with the low cycles preceding it.
  initial begin
    logic prev;
    int   low;
    prev = 1'b0; low = 0;
    forever begin
      @(negedge clk);
      if (mgmt_req && !prev) begin
        glog.push_back({mgmt_adr, mgmt_txd});
        gap.push_back(low);
      end
      low  = mgmt_req ? 0 : low + 1;
      prev = mgmt_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  task automatic timed(input int g, output int t);
    int k;
    k = 0; t = 0;
    while (!req[g] && k < 100) begin @(negedge clk); #1; k++; end
    while (!ackv[g] && t < 200) begin @(negedge clk); #1; t++; end
  endtask

  task automatic wait_mreq();
    int k;
    k = 0;
    while (!mgmt_req && k < 100) begin @(negedge clk); #1; k++; end
    check("mreq_wait", mgmt_req, 1'b1);
  endtask

  task automatic wait_done(input int n0, input int n1);
    int k;
    k = 0;
    while ((idx[0] < n0 || idx[1] < n1) && k < 400) begin @(negedge clk); #1; k++; end
    check("done_wait", {idx[0] >= n0, idx[1] >= n1}, 2'b11);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    int t, s, i0, i1;
    logic [63:0] expg [4];
    rstn = 1'b0; slat = 3; stray_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mgmt", {mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd}, '0);
    check("rst_m0", {m0_ack, m0_rxe, m0_rxd, m0_err}, '0);
    check("rst_m1", {m1_ack, m1_rxe, m1_rxd, m1_err}, '0);
    @(posedge clk); #2 rstn = 1'b1;

    // m0 reads the status register
    mq[0].push_back('{adr: ADR_MSTA, rwn: 1'b1, wen: 2'b00, txd: 32'h0});
    timed(0, t);
    check("rd_latency", t, 4);
    check("rd_rxd", m0_rxd, 32'h3);
    check("rd_rxe_err", {m0_rxe, m0_err}, 2'b10);
    check("rd_m1_quiet", m1_ack, 1'b0);

    // stray slave ack while idle is ignored
    repeat (3) @(negedge clk);
    #1 stray_cnt++;
    repeat (2) @(negedge clk);
    #1 check("stray_ignored", {m0_ack, m1_ack, mgmt_req}, 3'b000);

    // both masters write from reset: alternate m0, m1, m0, m1
    do_reset();
    s = glog.size(); i0 = idx[0]; i1 = idx[1];
    mq[0].push_back('{adr: 32'h100, rwn: 1'b0, wen: 2'b11, txd: 32'h1111_0000});
    mq[0].push_back('{adr: 32'h104, rwn: 1'b0, wen: 2'b11, txd: 32'h1111_0001});
    mq[1].push_back('{adr: 32'h200, rwn: 1'b0, wen: 2'b11, txd: 32'h2222_0000});
    mq[1].push_back('{adr: 32'h204, rwn: 1'b0, wen: 2'b11, txd: 32'h2222_0001});
    wait_done(i0 + 2, i1 + 2);
    expg[0] = {32'h100, 32'h1111_0000};
    expg[1] = {32'h200, 32'h2222_0000};
    expg[2] = {32'h104, 32'h1111_0001};
    expg[3] = {32'h204, 32'h2222_0001};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), (s + i < glog.size()) ? glog[s + i] : 64'h0, expg[i]);
      if (i > 0) check($sformatf("rr_gap%0d", i), (s + i < gap.size()) ? gap[s + i] : -1, 2);
    end

    // m1 upper-halfword write
    mq[1].push_back('{adr: 32'h0000_0020, rwn: 1'b0, wen: 2'b10, txd: 32'hDEAD_0000});
    wait_mreq();
    check("hw_wen", mgmt_wen, 2'b10);
    check("hw_txd", mgmt_txd, 32'hDEAD_0000);
    timed(1, t);
    check("hw_ack_rxe", {m1_ack, m1_rxe}, 2'b10);

    // slave ack lands on the 16th busy cycle: normal completion
    slat = 16;
    mq[0].push_back('{adr: 32'h0000_0040, rwn: 1'b1, wen: 2'b00, txd: 32'h0});
    timed(0, t);
    check("late_latency", t, 17);
    check("late_rsp", {m0_rxe, m0_rxd, m0_err}, {1'b1, 32'h5A5A_0040, 1'b0});

    // unmapped address
`ifdef MGMT_ARB_TIMEOUT_EN
    slat = 0;
    mq[0].push_back('{adr: 32'hBAD0_0000, rwn: 1'b1, wen: 2'b00, txd: 32'h0});
    timed(0, t);
    check("tmo_latency", t, 17);
    check("tmo_rsp", {m0_ack, m0_rxe, m0_rxd, m0_err}, {1'b1, 1'b0, 32'h0, 1'b1});
`else
    slat = 45;
    mq[0].push_back('{adr: 32'hBAD0_0000, rwn: 1'b1, wen: 2'b00, txd: 32'h0});
    timed(0, t);
    check("wait_latency", t, 46);
    check("wait_rsp", {m0_ack, m0_rxe, m0_err}, 3'b110);
`endif
    slat = 3;
    mq[0].push_back('{adr: ADR_MSTA, rwn: 1'b1, wen: 2'b00, txd: 32'h0});
    timed(0, t);
    check("after_latency", t, 4);
    check("after_rsp", {m0_rxd, m0_err}, {32'h3, 1'b0});

    // reset while m1 is in flight: m0 priority is restored afterwards
    slat = 0;
    i0 = idx[0]; i1 = idx[1];
    mq[1].push_back('{adr: 32'h300, rwn: 1'b0, wen: 2'b01, txd: 32'h0000_BEEF});
    wait_mreq();
    check("mid_m1_adr", mgmt_adr, 32'h300);
    repeat (3) @(negedge clk);
    #1 mq[0].push_back('{adr: 32'h400, rwn: 1'b1, wen: 2'b00, txd: 32'h0});
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    check("mid_rst_mreq", mgmt_req, 1'b0);
    check("mid_rst_acks", {m0_ack, m1_ack}, 2'b00);
    check("mid_rst_adr", mgmt_adr, 32'h0);
    slat = 3;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    wait_mreq();
    check("post_rst_winner", mgmt_adr, 32'h400);
    wait_done(i0 + 1, i1 + 1);
    check("post_rst_m1_last", glog[glog.size() - 1][63:32], 32'h300);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
